ysyx_22040365_ifu: RTL and testbench
====================================

Name: ysyx_22040365_ifu

Overview:
Instruction fetch unit; the producer end of the 32-bit instruction word consumed by the decode stage. Holds the PC, issues one request at a time to instruction memory over a req/ready + rvalid handshake, and buffers the returned word. Presents the word to decode with a valid/ready handshake and accepts redirects (jump/branch/trap targets) from later stages. Multi-cycle, single outstanding request, in-order.

Parameters:
XLEN, 64, PC and address width
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address, 4-byte aligned
imem_ready  input  1  memory accepts request this cycle (handshake = imem_req & imem_ready)
imem_rvalid  input  1  response data valid, exactly one per accepted request, earliest the cycle after acceptance
imem_rdata  input  32  fetched instruction word
inst_valid  output  1  buffered instruction valid to decode
inst  output  32  instruction word to decode
inst_pc  output  XLEN  PC of inst
inst_ready  input  1  decode consumes inst this cycle (transfer = inst_valid & inst_ready)
redirect_valid  input  1  redirect PC this cycle
redirect_pc  input  XLEN  redirect target; bits [1:0] forced to 0 internally

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. rst overrides all inputs in the cycle it is sampled.
- Reset values: pc=RESET_PC, state=REQ, drop=0, imem_req=0 during reset, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC.
- imem_req=1 and imem_addr=pc in state REQ only; combinational from state/pc, so req rises the first cycle after rst deasserts.
- States:
  - REQ: if imem_ready, go to WAIT. Else stay in REQ. imem_addr may change while not yet accepted (only on redirect).
  - WAIT: wait for imem_rvalid. On rvalid with drop=0, latch inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go to HOLD. On rvalid with drop=1, discard data, clear drop, go to REQ.
  - HOLD: inst_valid=1, inst and inst_pc stable. On inst_ready, inst_valid<=0, pc<=pc+PC_STEP (wraps mod 2^XLEN), go to REQ.
- Redirect handling (redirect_valid has priority over inst_ready and rvalid):
  - REQ without grant: pc<=redirect_pc; stay in REQ.
  - REQ with imem_ready in the same cycle: the request is already issued. pc<=redirect_pc, drop<=1, go to WAIT.
  - WAIT, rvalid=0: pc<=redirect_pc, drop<=1.
  - WAIT, rvalid=1: discard data, pc<=redirect_pc, drop<=0, go to REQ.
  - HOLD: inst_valid<=0, the buffered instruction is flushed even if inst_ready=1. pc<=redirect_pc, go to REQ.
  - Repeated redirects while drop=1: pc takes the newest target; still exactly one response is dropped.
- Latency and throughput: best-case 3 cycles per instruction (REQ granted, rvalid next cycle, consumed in HOLD). First inst_valid at the earliest 2 cycles after rst deasserts.
- Data integrity: a dropped response never appears on inst. inst_pc always equals the address that fetched inst.
- Reset during WAIT: state goes to REQ and the pending response is never delivered. Any rvalid in the cycle after reset is ignored; the memory side is reset by the same rst.

Decomposition:
- Shared defines file: RESET_PC value, PC_STEP, INST_NOP (32'h0000_0013), fetch state encodings (REQ, WAIT, HOLD; 2 bits).
- No sub-module required. The PC update mux (reset / redirect / pc+4 / hold) may be split out as ysyx_22040365_pc_reg if reused by a later pipelined fetch.

Test Plan:
- Reset then imem_ready=1 with rvalid one cycle after each grant, inst_ready=1: addrs 0x80000000, 0x80000004, 0x80000008 and inst_pc match; one inst every 3 cycles.
- inst_ready=0 for 5 cycles in HOLD: inst and inst_pc stable, no new imem_req. inst_ready=1 then gives next addr 0x80000004.
- Redirect to 0x80001002 in WAIT before rvalid: returned word is dropped, inst_valid stays 0, next imem_addr=0x80001000, next inst_pc=0x80001000.
- Redirect to 0x80002000 in HOLD with inst_ready=1 in the same cycle: no transfer counted, inst_valid->0, next imem_addr=0x80002000.
- imem_ready held 0 for 4 cycles, redirect to 0x80003000 in cycle 2: imem_addr switches to 0x80003000, accepted address is 0x80003000, no extra response consumed.
- rst asserted in WAIT: all outputs at reset values the next cycle, a stale rvalid is ignored, and fetch restarts at 0x80000000.

Source files
------------

// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared constants for the instruction fetch unit: reset PC, PC increment,
// the NOP placed on the decode port out of reset, and fetch state encodings.
package ysyx_22040365_ifu_pkg;

    localparam int unsigned XLEN_DEF     = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam int unsigned PC_STEP_DEF  = 4;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/ysyx_22040365_ifu_pc_reg.sv
// Fetch PC register: reset value, redirect load, sequential step, or hold.
// Kept separate so a later pipelined fetch can reuse the same update mux.
module ysyx_22040365_pc_reg #(
    parameter int unsigned       XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] STEP_INC = XLEN'(PC_STEP);

    logic [XLEN-1:0] pc_r;

    // PC update; a redirect always wins over a sequential step
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (load) begin
            pc_r <= target;
        end else if (step) begin
            pc_r <= pc_r + STEP_INC;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: one outstanding request to instruction memory,
// a single-entry buffer toward decode, and redirect handling with response drop.
module ysyx_22040365_ifu
    import ysyx_22040365_ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic            drop_r;
    logic            drop_nxt_s;
    logic            pc_load_s;
    logic            pc_step_s;
    logic            latch_s;
    logic            clear_s;
    logic [XLEN-1:0] pc_s;
    logic [XLEN-1:0] redirect_tgt_s;
    logic            inst_valid_r;
    logic [31:0]     inst_r;
    logic [XLEN-1:0] inst_pc_r;

    assign redirect_tgt_s = {redirect_pc[XLEN-1:2], 2'b00};

    ysyx_22040365_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (pc_load_s),
        .step   (pc_step_s),
        .target (redirect_tgt_s),
        .pc     (pc_s)
    );

    // Fetch sequencing; redirect outranks both rvalid and inst_ready
    always_comb begin
        state_nxt_s = state_r;
        drop_nxt_s  = drop_r;
        pc_load_s   = 1'b0;
        pc_step_s   = 1'b0;
        latch_s     = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_load_s = 1'b1;
                    if (imem_ready) begin
                        // old address is already in flight; its response must be discarded
                        state_nxt_s = ST_WAIT;
                        drop_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end else if (imem_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_load_s = 1'b1;
                    if (imem_rvalid) begin
                        state_nxt_s = ST_REQ;
                        drop_nxt_s  = 1'b0;
                    end else begin
                        drop_nxt_s  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_r) begin
                        drop_nxt_s  = 1'b0;
                        state_nxt_s = ST_REQ;
                    end else begin
                        latch_s     = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_load_s   = 1'b1;
                    clear_s     = 1'b1;
                    state_nxt_s = ST_REQ;
                end else if (inst_ready) begin
                    pc_step_s   = 1'b1;
                    clear_s     = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
                drop_nxt_s  = 1'b0;
                clear_s     = 1'b1;
            end
        endcase
    end

    // State and drop-pending flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_REQ;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            drop_r  <= drop_nxt_s;
        end
    end

    // Instruction buffer toward decode
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid_r <= 1'b0;
            inst_r       <= INST_NOP;
            inst_pc_r    <= RESET_PC;
        end else if (latch_s) begin
            inst_valid_r <= 1'b1;
            inst_r       <= imem_rdata;
            inst_pc_r    <= pc_s;
        end else if (clear_s) begin
            inst_valid_r <= 1'b0;
        end else begin
            inst_valid_r <= inst_valid_r;
        end
    end

    assign imem_req   = (state_r == ST_REQ) && !rst;
    assign imem_addr  = pc_s;
    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Self-checking bench for the fetch unit: a responding memory model plus a
// next-expected-PC reference, directed scenarios, then randomized traffic.
module tb_ysyx_22040365_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    ysyx_22040365_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state: PC of the next instruction decode should receive
    logic [63:0] exp_pc;
    bit          pend;
    int          pend_cnt;
    logic [63:0] pend_addr;
    int          ready_mode;
    int          lat_fix;
    bit          lat_rand;
    bit          force_stale;
    int          cyc;
    int          xfer_n;
    int          hs_n;
    bit          hs_now;
    bit          xfer_now;
    logic [63:0] last_hs_addr;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // one clock: drive memory side, check handshakes against the model, advance
    task automatic step();
        bit deliver;
        bit hs;
        bit xfer;
        @(negedge clk);
        deliver = !rst && pend && (pend_cnt == 0);
        case (ready_mode)
            0:       imem_ready = 1'b1;
            1:       imem_ready = ($urandom_range(0, 2) != 0);
            default: imem_ready = 1'b0;
        endcase
        if (deliver) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
        end else if (force_stale) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        hs   = imem_req && imem_ready;
        xfer = !rst && inst_valid && inst_ready && !redirect_valid;
        if (rst) begin
            check_eq("req_in_reset", 64'(imem_req), 64'd0);
            exp_pc = RST_PC;
            pend   = 1'b0;
        end else begin
            if (imem_req) check_eq("single_outstanding", 64'(pend), 64'd0);
            if (hs) check_eq("fetch_addr", imem_addr, exp_pc);
            if (xfer) begin
                check_eq("inst_pc", inst_pc, exp_pc);
                check_eq("inst_word", 64'(inst), 64'(mem_word(exp_pc)));
            end
            if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
            else if (xfer) exp_pc = exp_pc + 64'd4;
            if (deliver) pend = 1'b0;
            else if (pend) pend_cnt--;
            if (hs) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
                pend_cnt  = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
            end
        end
        hs_now   = hs;
        xfer_now = xfer;
        if (hs) begin
            hs_n++;
            last_hs_addr = imem_addr;
        end
        if (xfer) xfer_n++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        force_stale    = 1'b0;
        step();
        step();
        check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("rst_inst", 64'(inst), 64'(NOP));
        check_eq("rst_inst_pc", inst_pc, RST_PC);
        check_eq("rst_imem_req", 64'(imem_req), 64'd0);
        rst    = 1'b0;
        cyc    = 0;
        xfer_n = 0;
        hs_n   = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!inst_valid && n < 20) begin
            step();
            n++;
        end
        if (!inst_valid) check_eq(tag, 64'd0, 64'd1);
    endtask

    initial begin
        int          xc[$];
        logic [31:0] held_inst;
        logic [63:0] held_pc;
        int          r;

        rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        exp_pc = RST_PC; pend = 1'b0; pend_cnt = 0; pend_addr = 64'd0;
        ready_mode = 0; lat_fix = 0; lat_rand = 1'b0; force_stale = 1'b0;
        cyc = 0; xfer_n = 0; hs_n = 0; last_hs_addr = 64'd0;

        // back-to-back fetch: one instruction every 3 cycles
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            if (xfer_now) xc.push_back(cyc - 1);
        end
        check_eq("t1_xfer_count", 64'(xc.size()), 64'd3);
        for (int i = 0; i < xc.size() && i < 3; i++) check_eq("t1_xfer_cycle", 64'(xc[i]), 64'(2 + 3 * i));
        check_eq("t1_last_addr", last_hs_addr, 64'h8000_0008);

        // decode stalls for 5 cycles in HOLD
        do_reset();
        wait_valid("t2_timeout");
        held_inst = inst;
        held_pc   = inst_pc;
        check_eq("t2_pc", held_pc, RST_PC);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("t2_inst_stable", 64'(inst), 64'(held_inst));
            check_eq("t2_pc_stable", inst_pc, held_pc);
            check_eq("t2_no_req", 64'(imem_req), 64'd0);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        step();
        check_eq("t2_next_hs", 64'(hs_now), 64'd1);
        check_eq("t2_next_addr", last_hs_addr, 64'h8000_0004);

        // redirect while waiting for the response
        do_reset();
        inst_ready = 1'b1;
        lat_fix    = 2;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1002;
        step();
        redirect_valid = 1'b0;
        for (int k = 0; k < 10 && !hs_now; k++) begin
            step();
            if (!hs_now) check_eq("t3_no_valid", 64'(inst_valid), 64'd0);
        end
        check_eq("t3_next_addr", last_hs_addr, 64'h8000_1000);
        wait_valid("t3_timeout");
        check_eq("t3_inst_pc", inst_pc, 64'h8000_1000);
        check_eq("t3_inst", 64'(inst), 64'(mem_word(64'h8000_1000)));

        // redirect in HOLD with decode ready in the same cycle
        do_reset();
        lat_fix = 0;
        wait_valid("t4_timeout");
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        inst_ready     = 1'b1;
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        check_eq("t4_flushed", 64'(inst_valid), 64'd0);
        step();
        check_eq("t4_next_hs", 64'(hs_now), 64'd1);
        check_eq("t4_next_addr", last_hs_addr, 64'h8000_2000);

        // memory not ready, redirect before acceptance
        do_reset();
        ready_mode = 2;
        step();
        check_eq("t5_addr0", imem_addr, RST_PC);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3000;
        step();
        redirect_valid = 1'b0;
        check_eq("t5_addr1", imem_addr, 64'h8000_3000);
        step();
        step();
        check_eq("t5_req_held", 64'(imem_req), 64'd1);
        check_eq("t5_no_hs", 64'(hs_n), 64'd0);
        ready_mode = 0;
        inst_ready = 1'b1;
        step();
        check_eq("t5_accept_addr", last_hs_addr, 64'h8000_3000);
        wait_valid("t5_timeout");
        check_eq("t5_inst_pc", inst_pc, 64'h8000_3000);
        check_eq("t5_one_hs", 64'(hs_n), 64'd1);

        // reset while a response is pending, then a stale rvalid
        do_reset();
        lat_fix = 3;
        step();
        step();
        rst = 1'b1;
        step();
        check_eq("t6_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("t6_inst", 64'(inst), 64'(NOP));
        check_eq("t6_inst_pc", inst_pc, RST_PC);
        check_eq("t6_req", 64'(imem_req), 64'd0);
        rst         = 1'b0;
        force_stale = 1'b1;
        step();
        force_stale = 1'b0;
        check_eq("t6_restart_hs", 64'(hs_now), 64'd1);
        check_eq("t6_restart_addr", last_hs_addr, RST_PC);
        wait_valid("t6_timeout");
        check_eq("t6_inst_pc2", inst_pc, RST_PC);
        check_eq("t6_inst2", 64'(inst), 64'(mem_word(RST_PC)));

        // randomized traffic against the reference model
        do_reset();
        ready_mode = 1;
        lat_rand   = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            r = int'($urandom_range(0, 3));
            case (r)
                0:       redirect_pc = {32'd0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
                1:       redirect_pc = {$urandom, $urandom};
                2:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: redirect_pc = {32'd0, 32'h8000_0100 | ($urandom & 32'h0000_00FF)};
            endcase
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        check_eq("rand_progress", 64'(xfer_n > 200), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
